// File: rtl/player_press_queue_pkg.sv
// Shared types and constants for the player press queue.
package player_pkg;

   localparam int NUM_PLAYERS = 6;
   localparam int VAL_W       = 3;
   localparam int PID_W       = 3;

   typedef struct packed {
      logic [PID_W-1:0] pid;
      logic [VAL_W-1:0] val;
   } press_t;

   function automatic logic [PID_W-1:0] next_pid(input logic [PID_W-1:0] p);
      return (p == PID_W'(NUM_PLAYERS - 1)) ? '0 : p + 1'b1;
   endfunction

endpackage

// File: rtl/player_press_queue_if.sv
// Output handshake of the press queue: head entry valid/ready with player id and value.
interface player_press_queue_if;
   import player_pkg::*;

   logic             out_valid;
   logic             out_ready;
   logic [PID_W-1:0] out_pid;
   logic [VAL_W-1:0] out_val;

   modport master (output out_valid, output out_pid, output out_val, input out_ready);
   modport slave  (input out_valid, input out_pid, input out_val, output out_ready);

endinterface

// File: rtl/player_press_queue_fifo.sv
// press_fifo: synchronous FIFO of press_t entries with flush, occupancy and head output.
module press_fifo
   import player_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   push,
   input  press_t                 push_data,
   input  logic                   pop,
   output press_t                 head,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   press_t          r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;
   logic            w_push;
   logic            w_pop;

   assign empty  = (r_count == '0);
   assign full   = (r_count == (AW+1)'(DEPTH));
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;
   assign count  = r_count;
   assign head   = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !clr) r_mem[r_wr_ptr] <= push_data;
   end

endmodule

// File: rtl/player_press_queue.sv
// player_press_queue: per-player edge capture, round-robin arbiter and press FIFO.
// Optional macro PLAYER_PRESS_QUEUE_DROP_CNT_EN adds a saturating drop_cnt output.
module player_press_queue
   import player_pkg::press_t, player_pkg::VAL_W, player_pkg::PID_W, player_pkg::next_pid;
#(
   parameter int DEPTH       = 8,
   parameter int NUM_PLAYERS = player_pkg::NUM_PLAYERS
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic [NUM_PLAYERS-1:0]       btn_db,
   input  logic [NUM_PLAYERS*VAL_W-1:0] val_in,
   player_press_queue_if.master         out_if,
   output logic [$clog2(DEPTH):0]       count,
   output logic                         drop
`ifdef PLAYER_PRESS_QUEUE_DROP_CNT_EN
   ,
   output logic [7:0]                   drop_cnt
`endif
);

   logic [NUM_PLAYERS-1:0] r_prev;
   logic [NUM_PLAYERS-1:0] r_pend;
   logic [VAL_W-1:0]       r_pval [NUM_PLAYERS];
   logic [PID_W-1:0]       r_rr;
   logic                   r_drop;

   logic [NUM_PLAYERS-1:0] w_edge;
   logic [NUM_PLAYERS-1:0] w_pend_nxt;
   logic [VAL_W-1:0]       w_pval_nxt [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0] w_lost;
   logic                   w_gnt_vld;
   logic [PID_W-1:0]       w_gnt_id;
   logic [PID_W:0]         w_scan;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_pop;
   press_t                 w_push_data;
   press_t                 w_head;

   assign w_edge = btn_db & ~r_prev;

   // Scan pending flags starting at r_rr, wrapping modulo NUM_PLAYERS.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_id  = '0;
      w_scan    = '0;
      if (!w_full) begin
         for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
            w_scan = {1'b0, r_rr} + (PID_W+1)'(k);
            if (w_scan >= (PID_W+1)'(NUM_PLAYERS)) w_scan = w_scan - (PID_W+1)'(NUM_PLAYERS);
            if (!w_gnt_vld && r_pend[w_scan[PID_W-1:0]]) begin
               w_gnt_vld = 1'b1;
               w_gnt_id  = w_scan[PID_W-1:0];
            end
         end
      end
   end

   // A fresh edge on the player being granted re-arms its slot instead of dropping.
   always_comb begin
      w_pend_nxt = r_pend;
      w_pval_nxt = r_pval;
      w_lost     = '0;
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
         if (w_edge[i] && (!r_pend[i] || (w_gnt_vld && w_gnt_id == PID_W'(i)))) begin
            w_pend_nxt[i] = 1'b1;
            w_pval_nxt[i] = val_in[i*VAL_W +: VAL_W];
         end else if (w_edge[i]) begin
            w_lost[i] = 1'b1;
         end else if (w_gnt_vld && w_gnt_id == PID_W'(i)) begin
            w_pend_nxt[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev <= '0;
         r_pend <= '0;
         r_rr   <= '0;
         r_drop <= 1'b0;
         for (int unsigned i = 0; i < NUM_PLAYERS; i++) r_pval[i] <= '0;
      end else begin
         r_prev <= btn_db;
         if (clr) begin
            r_pend <= '0;
            r_rr   <= '0;
            r_drop <= 1'b0;
         end else begin
            r_pend <= w_pend_nxt;
            r_pval <= w_pval_nxt;
            r_drop <= |w_lost;
            if (w_gnt_vld) r_rr <= next_pid(w_gnt_id);
         end
      end
   end

`ifdef PLAYER_PRESS_QUEUE_DROP_CNT_EN
   logic [7:0] r_drop_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             r_drop_cnt <= '0;
      else if (clr)                           r_drop_cnt <= '0;
      else if (|w_lost && r_drop_cnt != '1)   r_drop_cnt <= r_drop_cnt + 1'b1;
   end

   assign drop_cnt = r_drop_cnt;
`endif

   assign w_push_data.pid = w_gnt_id;
   assign w_push_data.val = r_pval[w_gnt_id];
   assign w_pop           = ~w_empty & out_if.out_ready;

   press_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .push      (w_gnt_vld),
      .push_data (w_push_data),
      .pop       (w_pop),
      .head      (w_head),
      .empty     (w_empty),
      .full      (w_full),
      .count     (count)
   );

   assign out_if.out_valid = ~w_empty;
   assign out_if.out_pid   = w_head.pid;
   assign out_if.out_val   = w_head.val;
   assign drop             = r_drop;

endmodule

// File: tb/tb_player_press_queue.sv
// Directed bench for player_press_queue: latency, ordering, full/drop, stall, flush and reset.
module tb_player_press_queue;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic [5:0]  btn_db;
   logic [17:0] val_in;
   logic [3:0]  count;
   logic        drop;
`ifdef PLAYER_PRESS_QUEUE_DROP_CNT_EN
   logic [7:0]  drop_cnt;
`endif

   int unsigned n_checks;
   int unsigned n_errors;
   int unsigned drained;

   int unsigned exp_pid [10] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3};
   int unsigned exp_val [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};

   player_press_queue_if u_if ();

   player_press_queue #(
      .DEPTH       (8),
      .NUM_PLAYERS (6)
   ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .btn_db (btn_db),
      .val_in (val_in),
      .out_if (u_if.master),
      .count  (count),
      .drop   (drop)
`ifdef PLAYER_PRESS_QUEUE_DROP_CNT_EN
      ,
      .drop_cnt (drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      clr = 1'b0;
      btn_db = '0;
      val_in = '0;
      u_if.out_ready = 1'b0;
      tick();
      tick();
      check_eq("rst_valid", u_if.out_valid, 0);
      check_eq("rst_count", count, 0);
      check_eq("rst_drop", drop, 0);
      check_eq("rst_pid", u_if.out_pid, 0);
      check_eq("rst_val", u_if.out_val, 0);
      rst_n = 1'b1;
      tick();

      // Single press latency with consumer ready
      btn_db = 6'b000100;
      val_in = {3'd0, 3'd0, 3'd0, 3'd5, 3'd0, 3'd0};
      u_if.out_ready = 1'b1;
      tick();
      check_eq("lat_n1_valid", u_if.out_valid, 0);
      tick();
      check_eq("lat_n2_valid", u_if.out_valid, 1);
      check_eq("lat_pid", u_if.out_pid, 2);
      check_eq("lat_val", u_if.out_val, 5);
      check_eq("lat_count", count, 1);
      tick();
      check_eq("lat_popped_count", count, 0);
      check_eq("lat_popped_valid", u_if.out_valid, 0);

      // Six simultaneous presses, ordered 0..5 from rr_ptr 0
      btn_db = '0;
      u_if.out_ready = 1'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      btn_db = 6'b111111;
      val_in = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      repeat (7) tick();
      check_eq("six_count", count, 6);
      check_eq("six_drop", drop, 0);
      u_if.out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         check_eq("six_pid", u_if.out_pid, k);
         check_eq("six_val", u_if.out_val, k);
         tick();
      end
      check_eq("six_drained", count, 0);

      // Fill to DEPTH, then pending players hold and a re-press drops
      btn_db = '0;
      u_if.out_ready = 1'b0;
      tick();
      for (int j = 0; j < 10; j++) begin
         btn_db = 6'(1 << (j % 6));
         val_in = {6{j[2:0]}};
         tick();
         btn_db = '0;
         tick();
      end
      check_eq("full_count", count, 8);
      check_eq("full_head_pid", u_if.out_pid, 0);
      check_eq("full_head_val", u_if.out_val, 0);
      btn_db = 6'b000100;
      val_in = {6{3'd2}};
      tick();
      btn_db = '0;
      check_eq("drop_pulse", drop, 1);
      check_eq("drop_full_count", count, 8);
`ifdef PLAYER_PRESS_QUEUE_DROP_CNT_EN
      check_eq("drop_cnt_one", drop_cnt, 1);
`endif
      tick();
      check_eq("drop_one_cycle", drop, 0);
      u_if.out_ready = 1'b1;
      drained = 0;
      for (int c = 0; c < 30 && drained < 10; c++) begin
         if (u_if.out_valid) begin
            check_eq("drain_pid", u_if.out_pid, exp_pid[drained]);
            check_eq("drain_val", u_if.out_val, exp_val[drained]);
            drained++;
         end
         tick();
      end
      check_eq("drain_done", drained, 10);
      check_eq("drain_count", count, 0);

      // Stalled head stays stable; push+pop keeps count
      u_if.out_ready = 1'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      btn_db = 6'b001110;
      val_in = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2};
      repeat (4) tick();
      check_eq("stall_count", count, 3);
      for (int s = 0; s < 5; s++) begin
         tick();
         check_eq("stall_valid", u_if.out_valid, 1);
         check_eq("stall_pid", u_if.out_pid, 1);
         check_eq("stall_val", u_if.out_val, 3);
      end
      btn_db = 6'b011110;
      tick();
      u_if.out_ready = 1'b1;
      tick();
      u_if.out_ready = 1'b0;
      check_eq("pushpop_count", count, 3);
      check_eq("pushpop_pid", u_if.out_pid, 2);
      check_eq("pushpop_val", u_if.out_val, 4);

      // Flush with entries and pending flags while btn_db[0] is held
      btn_db = '0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      btn_db = 6'b111010;
      val_in = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      repeat (5) tick();
      check_eq("preclr_count", count, 4);
      btn_db = 6'b111111;
      tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check_eq("clr_count", count, 0);
      check_eq("clr_valid", u_if.out_valid, 0);
      check_eq("clr_drop", drop, 0);
`ifdef PLAYER_PRESS_QUEUE_DROP_CNT_EN
      check_eq("clr_drop_cnt", drop_cnt, 0);
`endif
      for (int s = 0; s < 3; s++) begin
         tick();
         check_eq("clr_no_refire", count, 0);
      end
      btn_db = 6'b111110;
      tick();
      btn_db = 6'b111111;
      val_in = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd6};
      tick();
      tick();
      check_eq("repress_count", count, 1);
      check_eq("repress_pid", u_if.out_pid, 0);
      check_eq("repress_val", u_if.out_val, 6);

      // Asynchronous reset mid-stream, btn_db[4] held through release
      #2;
      rst_n = 1'b0;
      btn_db = 6'b010000;
      val_in = {3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0};
      #1;
      check_eq("arst_valid", u_if.out_valid, 0);
      check_eq("arst_count", count, 0);
      check_eq("arst_pid", u_if.out_pid, 0);
      check_eq("arst_val", u_if.out_val, 0);
      check_eq("arst_drop", drop, 0);
`ifdef PLAYER_PRESS_QUEUE_DROP_CNT_EN
      check_eq("arst_drop_cnt", drop_cnt, 0);
`endif
      #2;
      rst_n = 1'b1;
      repeat (3) tick();
      check_eq("held_count", count, 1);
      check_eq("held_pid", u_if.out_pid, 4);
      check_eq("held_val", u_if.out_val, 3);
      repeat (3) tick();
      check_eq("held_once", count, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/player_press_queue.md
PLAYER_PRESS_QUEUE -- requirements
Module: player_press_queue

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two, 2..64.
REQ-002 Parameter NUM_PLAYERS, default 6, number of player channels; fixed at 6 in this revision.
REQ-003 Port clk  input  1  system clock, 100 MHz.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port clr  input  1  synchronous queue flush, active-high.
REQ-006 Port btn_db  input  6  debounced player strobe levels, clk domain; bit i = player i+1.
REQ-007 Port val_in  input  18  player values; bits [3i+2:3i] = player i+1.
REQ-008 Port out_valid  output  1  head entry available.
REQ-009 Port out_ready  input  1  consumer accepts head.
REQ-010 Port out_pid  output  3  head player id, 0..5.
REQ-011 Port out_val  output  3  head value.
REQ-012 Port count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-013 Port drop  output  1  one-cycle pulse on a lost press.

Function
REQ-014 Per player, prev[i] SHALL register btn_db[i]; edge[i] = btn_db[i] & ~prev[i].
REQ-015 On edge[i] with pend[i]=0, pend[i] SHALL set and pval[i] SHALL capture val_in slice i from the same cycle.
REQ-016 On edge[i] with pend[i]=1 and no grant to i that cycle, the new press SHALL be discarded, pval[i] kept, and drop pulsed.
REQ-017 The arbiter SHALL grant at most one pending player per cycle, only when count < DEPTH, choosing the first set pend index at or after rr_ptr (modulo 6).
REQ-018 On grant g: push {g, pval[g]}, clear pend[g], set rr_ptr to (g+1) mod 6.
REQ-019 If edge[g] coincides with grant g, pend[g] SHALL remain set with the new value, and no drop SHALL occur.
REQ-020 A pop SHALL occur when out_valid & out_ready; out_valid = (count != 0).
REQ-021 out_pid/out_val SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-023 When full, no grant SHALL occur; pending flags SHALL hold, and edges on pending players drop per REQ-016.
REQ-024 Latency: edge in cycle N -> grant in N+1 -> out_valid high in N+2 when queue is empty.
REQ-025 clr SHALL empty the FIFO, clear pend, and reset rr_ptr to 0 next cycle, with no drop pulse; prev SHALL be kept so held buttons do not refire.
REQ-026 clr has priority over edge capture, grant, and pop in the same cycle.

Reset
REQ-027 rst_n low SHALL clear prev, pend, pval, rr_ptr, FIFO pointers, count, drop, and the drop counter asynchronously; out_valid=0, out_pid=0, out_val=0.
REQ-028 Reset mid-operation SHALL discard all queued and pending presses; a button held through reset release SHALL produce one edge.

Configuration
REQ-029 Macro PLAYER_PRESS_QUEUE_DROP_CNT_EN defined: add output drop_cnt [7:0], incremented per drop pulse, saturating at 255, cleared by rst_n and clr.
REQ-030 Macro undefined: drop_cnt port and counter SHALL be absent; drop pulse unchanged.

Structure
REQ-031 Shared package player_pkg SHALL hold NUM_PLAYERS=6, VAL_W=3, PID_W=3, and typedef press_t {pid[2:0], val[2:0]}.
REQ-032 Storage SHALL be a sub-module press_fifo (synchronous, registered head, full/empty/count); arbiter and edge logic stay in player_press_queue.

Verification
REQ-033 Empty queue, btn_db[2] rises with val_in slice 2=5, out_ready=1 -> out_valid in N+2 with pid=2, val=5, popped that cycle, count back to 0.
REQ-034 All six strobes rise in the same cycle, vals 0..5, out_ready=0 -> six entries in order pid 0..5, count=6; then ready=1 drains in that order.
REQ-035 DEPTH=8, out_ready=0, 10 presses over distinct players/cycles -> count saturates at 8; remaining pending hold; a re-press of a pending player pulses drop; drop_cnt=1 when macro defined.
REQ-036 Head pid=1 with ready=0 for 5 cycles -> out_pid/out_val stable; simultaneous push+pop at count=3 -> count stays 3.
REQ-037 clr asserted with count=4 and pend=6'b000101 while btn_db[0] is held -> next cycle count=0, pend=0, no drop, no new entry until btn_db[0] falls and rises again.
REQ-038 rst_n pulsed low mid-stream -> all outputs 0 immediately; after release, a held btn_db[4] yields exactly one entry with pid=4.
